// File: rtl/stepper_phase_driver.sv
// stepper_phase_driver
// Drives the four coils of a bipolar stepper bridge from patterns handed over
// by the stepper ROM. Each new pattern gets an optional break-before-make gap
// (all coils off), then a minimum hold time, after which the next pattern may
// be accepted. Patterns that would short a bridge leg set a sticky fault.
//
// Optional feature: define STEPPER_IDLE_TIMEOUT_EN to de-energize the coils
// after IDLE_TIMEOUT consecutive READY cycles. Without it the last pattern is
// held indefinitely.

module stepper_phase_driver #(
  parameter logic [15:0] IDLE_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] phase_in,
  input  logic       phase_valid,
  output logic       phase_ready,
  input  logic       enable,
  input  logic [3:0] dead_cycles,
  input  logic [7:0] hold_cycles,
  input  logic       fault_clr,
  output logic [3:0] coils,
  output logic       fault,
  output logic       energized
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    READY = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pat_q, pat_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] coils_d;
  logic       fault_d;
  logic       fault_set;
  logic       xfer;
  logic       illegal;
  logic [7:0] hold_eff;

`ifdef STEPPER_IDLE_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

  // Handshake: only IDLE/READY accept, never while disabled, faulted or in reset.
  assign phase_ready = enable & ~fault & ~reset &
                       ((state_q == IDLE) | (state_q == READY));

  assign xfer = phase_valid & phase_ready;

  // A+ with A- or B+ with B- would short a half-bridge.
  assign illegal = (phase_in[0] & phase_in[2]) | (phase_in[1] & phase_in[3]);

  // A zero hold still gives the pattern one DRIVE cycle.
  assign hold_eff = (hold_cycles == 8'd0) ? 8'd1 : hold_cycles;

  // Next-state, coil and counter logic.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    hold_d    = hold_q;
    coils_d   = coils;
    fault_set = 1'b0;
`ifdef STEPPER_IDLE_TIMEOUT_EN
    idle_cnt_d = 16'd0;
`endif

    if (!enable) begin
      // Abort whatever is in progress and drop the pending pattern.
      state_d = IDLE;
      coils_d = 4'd0;
      cnt_d   = 8'd0;
      pat_d   = 4'd0;
    end else if (xfer) begin
      if (illegal) begin
        fault_set = 1'b1;
        state_d   = IDLE;
        coils_d   = 4'd0;
        cnt_d     = 8'd0;
        pat_d     = 4'd0;
      end else begin
        // Timing parameters are captured here so later changes do not
        // disturb this transition.
        pat_d  = phase_in;
        hold_d = hold_eff;
        if ((dead_cycles != 4'd0) && (phase_in != coils)) begin
          state_d = DEAD;
          coils_d = 4'd0;
          cnt_d   = {4'd0, dead_cycles};
        end else begin
          state_d = DRIVE;
          coils_d = phase_in;
          cnt_d   = hold_eff;
        end
      end
    end else begin
      case (state_q)
        DEAD: begin
          if (cnt_q <= 8'd1) begin
            state_d = DRIVE;
            coils_d = pat_q;
            cnt_d   = hold_q;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        DRIVE: begin
          if (cnt_q <= 8'd1) begin
            state_d = READY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        READY: begin
`ifdef STEPPER_IDLE_TIMEOUT_EN
          if (idle_cnt_q == IDLE_TIMEOUT - 16'd1) begin
            state_d = IDLE;
            coils_d = 4'd0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
`endif
        end
        default: begin
        end
      endcase
    end

    // A new fault outranks a simultaneous clear.
    fault_d = fault_set | (fault & ~fault_clr);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pat_q     <= 4'd0;
      hold_q    <= 8'd0;
      coils     <= 4'd0;
      fault     <= 1'b0;
      energized <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      hold_q    <= hold_d;
      coils     <= coils_d;
      fault     <= fault_d;
      energized <= (coils_d != 4'd0);
    end
  end

`ifdef STEPPER_IDLE_TIMEOUT_EN
  // Consecutive-READY counter for the idle de-energize.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Self-checking bench for stepper_phase_driver. A schedule-based reference
// model (absolute edge numbers for drive start and ready) predicts coils,
// fault, energized and phase_ready every cycle. Directed scenarios are
// followed by randomized traffic.

module tb_stepper_phase_driver;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] phase_in;
  logic       phase_valid;
  logic       phase_ready;
  logic       enable;
  logic [3:0] dead_cycles;
  logic [7:0] hold_cycles;
  logic       fault_clr;
  logic [3:0] coils;
  logic       fault;
  logic       energized;

  always #5 clk = ~clk;

  stepper_phase_driver #(.IDLE_TIMEOUT(16'(TO))) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .phase_ready (phase_ready),
    .enable      (enable),
    .dead_cycles (dead_cycles),
    .hold_cycles (hold_cycles),
    .fault_clr   (fault_clr),
    .coils       (coils),
    .fault       (fault),
    .energized   (energized)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: edge numbers at which the coils take the target
  // pattern and at which the block becomes ready again.
  logic [3:0] m_coils  = 4'd0;
  bit         m_fault  = 1'b0;
  bit         m_busy   = 1'b0;
  int         drive_at = 0;
  int         ready_at = 0;
  logic [3:0] target   = 4'd0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_illegal(input logic [3:0] p);
    return (p[0] && p[2]) || (p[1] && p[3]);
  endfunction

  function automatic bit m_ready();
    return !reset && enable && !m_fault && (!m_busy || cyc >= ready_at);
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit rdy;
    bit set;
    int gap;
    int hold;
    rdy = m_ready();
    set = 1'b0;
    cyc++;
    if (reset) begin
      m_coils = 4'd0;
      m_fault = 1'b0;
      m_busy  = 1'b0;
      return;
    end
    if (!enable) begin
      m_busy  = 1'b0;
      m_coils = 4'd0;
    end else if (phase_valid && rdy) begin
      if (is_illegal(phase_in)) begin
        set     = 1'b1;
        m_busy  = 1'b0;
        m_coils = 4'd0;
      end else begin
        gap      = (dead_cycles != 0 && phase_in != m_coils) ? int'(dead_cycles) : 0;
        hold     = (hold_cycles == 0) ? 1 : int'(hold_cycles);
        target   = phase_in;
        drive_at = cyc + gap;
        ready_at = drive_at + hold;
        m_busy   = 1'b1;
        m_coils  = (gap != 0) ? 4'd0 : target;
      end
    end else if (m_busy) begin
      if (cyc == drive_at) m_coils = target;
`ifdef STEPPER_IDLE_TIMEOUT_EN
      if (cyc == ready_at + TO) begin
        m_coils = 4'd0;
        m_busy  = 1'b0;
      end
`endif
    end
    m_fault = set || (m_fault && !fault_clr);
  endtask

  // One clock: check ready against current inputs, clock, then check outputs.
  task automatic cycle();
    #1;
    check("ready", {15'd0, phase_ready}, {15'd0, m_ready()});
    @(posedge clk);
    model_edge();
    #1;
    check("coils", {12'd0, coils}, {12'd0, m_coils});
    check("fault", {15'd0, fault}, {15'd0, m_fault});
    check("energized", {15'd0, energized}, {15'd0, (m_coils != 4'd0)});
  endtask

  task automatic idle_inputs();
    phase_valid = 1'b0;
    fault_clr   = 1'b0;
    reset       = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    phase_in    = 4'd0;
    phase_valid = 1'b0;
    dead_cycles = 4'd0;
    hold_cycles = 8'd0;
    fault_clr   = 1'b0;
    cycle();
    cycle();
    check("reset_coils", {12'd0, coils}, 16'd0);
    check("reset_fault", {15'd0, fault}, 16'd0);
    check("reset_ready", {15'd0, phase_ready}, 16'd0);

    // Dead gap of 3, hold of 5 from IDLE.
    reset = 1'b0;
    enable = 1'b1;
    dead_cycles = 4'd3;
    hold_cycles = 8'd5;
    phase_in = 4'b0001;
    phase_valid = 1'b1;
    cycle();
    check("dead_t0", {12'd0, coils}, 16'd0);
    phase_valid = 1'b0;
    dead_cycles = 4'd9;   // must not affect the transition in progress
    hold_cycles = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("dead_seq_coils", {12'd0, coils}, (k < 3) ? 16'd0 : 16'd1);
      #1;
      check("dead_seq_ready", {15'd0, phase_ready}, (k >= 8) ? 16'd1 : 16'd0);
    end

    // Direct step without a gap.
    dead_cycles = 4'd0;
    hold_cycles = 8'd2;
    phase_in = 4'b0011;
    phase_valid = 1'b1;
    cycle();
    check("nogap_coils", {12'd0, coils}, 16'h3);
    phase_valid = 1'b0;
    cycle();
    cycle();

    // Illegal pattern, then clear.
    phase_in = 4'b0101;
    phase_valid = 1'b1;
    cycle();
    check("illegal_fault", {15'd0, fault}, 16'd1);
    check("illegal_coils", {12'd0, coils}, 16'd0);
    #1;
    check("illegal_ready", {15'd0, phase_ready}, 16'd0);
    phase_valid = 1'b0;
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    check("clr_fault", {15'd0, fault}, 16'd0);
    #1;
    check("clr_ready", {15'd0, phase_ready}, 16'd1);

    // Enable drop during DRIVE with valid held.
    hold_cycles = 8'd8;
    phase_in = 4'b0001;
    phase_valid = 1'b1;
    cycle();
    phase_in = 4'b0010;
    cycle();
    cycle();
    enable = 1'b0;
    cycle();
    check("abort_coils", {12'd0, coils}, 16'd0);
    cycle();
    enable = 1'b1;
    cycle();
    phase_valid = 1'b0;
    for (int k = 0; k < 10; k++) cycle();

    // Reset during DEAD: the latched pattern must never appear.
    dead_cycles = 4'd4;
    phase_in = 4'b1000;
    phase_valid = 1'b1;
    cycle();
    phase_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rst_dead_coils", {12'd0, coils}, 16'd0);
    end

    // Long hold in READY.
    dead_cycles = 4'd0;
    hold_cycles = 8'd1;
    phase_in = 4'b1000;
    phase_valid = 1'b1;
    cycle();
    phase_valid = 1'b0;
    for (int k = 0; k < 100; k++) cycle();
`ifdef STEPPER_IDLE_TIMEOUT_EN
    check("timeout_coils", {12'd0, coils}, 16'd0);
`else
    check("hold_coils", {12'd0, coils}, 16'h8);
`endif

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] p;
      p = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) begin
        while (is_illegal(p)) p = 4'($urandom_range(0, 15));
      end
      phase_in    = p;
      phase_valid = ($urandom_range(0, 2) != 0);
      enable      = ($urandom_range(0, 29) != 0);
      fault_clr   = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      dead_cycles = 4'($urandom_range(0, 4));
      hold_cycles = 8'($urandom_range(0, 6));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
